main_memory_responder: RTL and testbench
========================================

Name: main_memory_responder

Overview:
Word-addressed main-memory responder on the processor's memory bus. The microcoded control unit is the initiator: it drives RD or WRMain as levels and holds address and data. This block answers each request with a one-cycle ACK after a programmable wait latency. It owns a synchronous RAM array, a read-data register and a small handshake FSM.

Parameters:
DATAWIDTH_BUS, 32, width of write data and read data.
DATAWIDTH_ADDRESS, 32, width of the incoming byte address.
DEPTH_LOG2, 10, log2 of the number of words stored.
LATENCY, 2, wait cycles between request capture and ACK; range 0..15.

Ports:
MAIN_MEMORY_CLOCK_50  in  1  system clock; all state changes on the rising edge.
MAIN_MEMORY_ResetInLow_In  in  1  asynchronous, active-low reset.
MAIN_MEMORY_RD_In  in  1  read request level from the control unit.
MAIN_MEMORY_WR_In  in  1  write request level from the control unit.
MAIN_MEMORY_Address_InBus  in  DATAWIDTH_ADDRESS  byte address.
MAIN_MEMORY_Data_InBus  in  DATAWIDTH_BUS  write data.
MAIN_MEMORY_Data_OutBus  out  DATAWIDTH_BUS  read data register.
MAIN_MEMORY_ACK_Out  out  1  one-cycle completion pulse.
MAIN_MEMORY_Busy_Out  out  1  high while a transaction is in flight.
MAIN_MEMORY_Error_Out  out  1  sticky; set on a request with RD and WR both high.

Behaviour:
- Reset (asynchronous, active-low):
  - Data_OutBus=0, ACK=0, Busy=0, Error=0.
  - FSM goes to IDLE; wait counter=0.
  - RAM contents are not cleared.
- Address mapping: word index = Address[DEPTH_LOG2+1:2].
  - Bits [1:0] are ignored (misaligned addresses round down).
  - Bits above DEPTH_LOG2+1 are ignored (the array aliases/wraps).
- IDLE:
  - If RD or WR is high, latch op, word index and write data, then go to WAIT. Busy=1 from the next cycle.
  - If LATENCY=0, go straight to RESP instead of WAIT.
  - If RD and WR are both high, set Error, latch op=NOP, then proceed normally.
- WAIT:
  - Counter increments each cycle.
  - When counter=LATENCY-1, go to RESP. The counter then clears.
  - Input changes during WAIT are ignored because the captured values are used.
- RESP (exactly one cycle):
  - ACK=1, Busy=1.
  - Write: RAM[index] <= latched data at the end of this cycle.
  - Read: Data_OutBus <= RAM[index] at the end of this cycle, so the data is valid from the cycle after ACK.
  - NOP: no RAM or Data_OutBus change.
  - Next state is IDLE unconditionally.
- Timing: ACK rises LATENCY+1 cycles after the capture edge.
  - The request level still high during RESP does not start a new transaction.
  - A request high in the IDLE cycle after RESP starts a new transaction. Back-to-back operation therefore costs LATENCY+2 cycles per access.
- Data_OutBus holds its value until the next completed read. Writes do not change it.
- Read-after-write to the same word in consecutive transactions returns the new data.
- Reset asserted in WAIT or RESP aborts the transaction:
  - A write whose RESP edge has not completed is not performed.
  - No ACK is issued after reset releases.
- Error clears only on reset.
- Implementation: a single-port RAM inferred with a synchronous write. The read is registered into Data_OutBus, so there is no combinational path from the address inputs to the outputs.

Test Plan:
- Reset then idle: hold ResetInLow=0, then release with RD=WR=0 for 10 cycles -> Data_OutBus=0, ACK, Busy and Error all 0 throughout.
- Write then read, LATENCY=2: WR=1, Address=0x00000010, Data_In=0xDEADBEEF -> ACK high exactly on the 3rd cycle after capture. Then RD=1 on the same address -> Data_OutBus=0xDEADBEEF the cycle after ACK.
- Aliasing and misalignment, DEPTH_LOG2=10: write 0x12345678 at 0x00001003. Read 0x00000000, then read 0x00001000 -> both return 0x12345678.
- Request held through ACK: keep RD=1 continuously for 12 cycles -> exactly one ACK every LATENCY+2=4 cycles, with ACK never high on two consecutive cycles.
- RD and WR both high at address 0x20 holding 0xA5A5A5A5 -> Error=1 and stays set, ACK is still issued, and RAM plus Data_OutBus are unchanged on a following read of 0x20.
- Reset mid-write: WR to 0x40 with 0x11111111 (previously 0x22222222), assert reset during WAIT -> no ACK. After release, a read of 0x40 returns 0x22222222.

Source files
------------

// File: rtl/main_memory_responder.sv
// Word-addressed memory responder: captures an RD/WR level, waits LATENCY cycles, then pulses ACK for one cycle.
// ACK in the LATENCY+1'th cycle after capture; requests are accepted only in IDLE, so the initiator is held off by Busy.
module main_memory_responder #(
    parameter int DATAWIDTH_BUS     = 32,
    parameter int DATAWIDTH_ADDRESS = 32,
    parameter int DEPTH_LOG2        = 10,
    parameter int LATENCY           = 2
) (
    input  logic                         MAIN_MEMORY_CLOCK_50,
    input  logic                         MAIN_MEMORY_ResetInLow_In,
    input  logic                         MAIN_MEMORY_RD_In,
    input  logic                         MAIN_MEMORY_WR_In,
    input  logic [DATAWIDTH_ADDRESS-1:0] MAIN_MEMORY_Address_InBus,
    input  logic [DATAWIDTH_BUS-1:0]     MAIN_MEMORY_Data_InBus,
    output logic [DATAWIDTH_BUS-1:0]     MAIN_MEMORY_Data_OutBus,
    output logic                         MAIN_MEMORY_ACK_Out,
    output logic                         MAIN_MEMORY_Busy_Out,
    output logic                         MAIN_MEMORY_Error_Out
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {OP_NOP, OP_RD, OP_WR} op_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic                    w_capture;
    op_t                     r_op;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [DATAWIDTH_BUS-1:0] r_wdat;
    logic [DATAWIDTH_BUS-1:0] r_dout;
    logic                    r_err;
    logic [DATAWIDTH_BUS-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_unused_addr;

    // Byte offset and upper address bits are dropped: misaligned rounds down, high bits alias.
    assign w_idx         = MAIN_MEMORY_Address_InBus[DEPTH_LOG2+1:2];
    assign w_unused_addr = ^{MAIN_MEMORY_Address_InBus[DATAWIDTH_ADDRESS-1:DEPTH_LOG2+2],
                             MAIN_MEMORY_Address_InBus[1:0]};

    always_ff @(posedge MAIN_MEMORY_CLOCK_50 or negedge MAIN_MEMORY_ResetInLow_In) begin
        if (!MAIN_MEMORY_ResetInLow_In) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MAIN_MEMORY_RD_In || MAIN_MEMORY_WR_In) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == LAT_M1) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Request is snapshotted at capture so input changes during WAIT have no effect.
    always_ff @(posedge MAIN_MEMORY_CLOCK_50 or negedge MAIN_MEMORY_ResetInLow_In) begin
        if (!MAIN_MEMORY_ResetInLow_In) begin
            r_op   <= OP_NOP;
            r_idx  <= '0;
            r_wdat <= '0;
            r_err  <= 1'b0;
        end else if (w_capture) begin
            r_idx  <= w_idx;
            r_wdat <= MAIN_MEMORY_Data_InBus;
            if (MAIN_MEMORY_RD_In && MAIN_MEMORY_WR_In) begin
                r_op  <= OP_NOP;
                r_err <= 1'b1;
            end else if (MAIN_MEMORY_WR_In) begin
                r_op <= OP_WR;
            end else begin
                r_op <= OP_RD;
            end
        end
    end

    // Reset forces r_state to IDLE asynchronously, so an aborted write never reaches this edge.
    always_ff @(posedge MAIN_MEMORY_CLOCK_50) begin
        if (r_state == S_RESP && r_op == OP_WR) begin
            r_mem[r_idx] <= r_wdat;
        end
    end

    always_ff @(posedge MAIN_MEMORY_CLOCK_50 or negedge MAIN_MEMORY_ResetInLow_In) begin
        if (!MAIN_MEMORY_ResetInLow_In) begin
            r_dout <= '0;
        end else if (r_state == S_RESP && r_op == OP_RD) begin
            r_dout <= r_mem[r_idx];
        end
    end

    assign MAIN_MEMORY_Data_OutBus = r_dout;
    assign MAIN_MEMORY_ACK_Out     = (r_state == S_RESP);
    assign MAIN_MEMORY_Busy_Out    = (r_state != S_IDLE);
    assign MAIN_MEMORY_Error_Out   = r_err;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder with LATENCY=2, DEPTH_LOG2=10.
module tb_main_memory_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] dout;
    logic        ack;
    logic        busy;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    main_memory_responder #(
        .DATAWIDTH_BUS     (32),
        .DATAWIDTH_ADDRESS (32),
        .DEPTH_LOG2        (10),
        .LATENCY           (2)
    ) dut (
        .MAIN_MEMORY_CLOCK_50      (clk),
        .MAIN_MEMORY_ResetInLow_In (rst_n),
        .MAIN_MEMORY_RD_In         (rd),
        .MAIN_MEMORY_WR_In         (wr),
        .MAIN_MEMORY_Address_InBus (addr),
        .MAIN_MEMORY_Data_InBus    (din),
        .MAIN_MEMORY_Data_OutBus   (dout),
        .MAIN_MEMORY_ACK_Out       (ack),
        .MAIN_MEMORY_Busy_Out      (busy),
        .MAIN_MEMORY_Error_Out     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request held until ACK; returns in the IDLE cycle after RESP.
    task automatic xact(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        int lat;
        lat = 0;
        @(negedge clk);
        rd = r; wr = w; addr = a; din = d;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack) begin
                lat = i;
                break;
            end
            chk("busy_wait", {31'd0, busy}, 32'd1);
        end
        rd = 1'b0; wr = 1'b0;
        chk("ack_lat", lat, 32'd3);
        @(negedge clk);
        chk("ack_pulse", {31'd0, ack}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 32'd0);
        chk("rst_flags", {29'd0, ack, busy, err}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_dout", dout, 32'd0);
            chk("idle_flags", {29'd0, ack, busy, err}, 32'd0);
        end

        xact(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("wr_no_dout", dout, 32'd0);
        xact(1'b1, 1'b0, 32'h0000_0010, 32'd0);
        chk("rd_10", dout, 32'hDEAD_BEEF);

        xact(1'b0, 1'b1, 32'h0000_1003, 32'h1234_5678);
        xact(1'b1, 1'b0, 32'h0000_0000, 32'd0);
        chk("rd_alias0", dout, 32'h1234_5678);
        xact(1'b1, 1'b0, 32'h0000_1000, 32'd0);
        chk("rd_alias1000", dout, 32'h1234_5678);
        xact(1'b1, 1'b0, 32'h0000_0010, 32'd0);
        chk("rd_10_again", dout, 32'hDEAD_BEEF);

        @(negedge clk);
        rd = 1'b1; addr = 32'h0000_0010;
        for (int s = 1; s <= 12; s++) begin
            @(negedge clk);
            chk("held_ack", {31'd0, ack}, (s % 4 == 3) ? 32'd1 : 32'd0);
        end
        rd = 1'b0;
        @(negedge clk);
        chk("held_dout", dout, 32'hDEAD_BEEF);

        xact(1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
        chk("err_before", {31'd0, err}, 32'd0);
        xact(1'b1, 1'b1, 32'h0000_0020, 32'h5A5A_5A5A);
        chk("err_set", {31'd0, err}, 32'd1);
        chk("nop_dout", dout, 32'hDEAD_BEEF);
        xact(1'b1, 1'b0, 32'h0000_0020, 32'd0);
        chk("nop_ram", dout, 32'hA5A5_A5A5);
        chk("err_sticky", {31'd0, err}, 32'd1);

        xact(1'b0, 1'b1, 32'h0000_0040, 32'h2222_2222);
        @(negedge clk);
        wr = 1'b1; addr = 32'h0000_0040; din = 32'h1111_1111;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        wr = 1'b0;
        #1;
        chk("abort_flags", {29'd0, ack, busy, err}, 32'd0);
        chk("abort_dout", dout, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_ack", {31'd0, ack}, 32'd0);
        end
        xact(1'b1, 1'b0, 32'h0000_0040, 32'd0);
        chk("abort_ram", dout, 32'h2222_2222);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
